bm_interlock_scan_ctrl: RTL and testbench
=========================================

Name: bm_interlock_scan_ctrl

Overview:
Frame sequencer for the beam-monitor position interlock datapath. On each frame tick it walks all BPM addresses, reads X/Y and the mask bit from the position RAM, and presents the data with a tag to the interlock comparator. It collects the returned fault flags, latches the first faulted address and keeps the trip latched until a clear handshake completes.

Parameters:
NUM_BPM, 180, number of BPM addresses scanned per frame (2..1023)
ADDR_W, 10, address width
PIPE_LAT, 2, cycles from il_valid to the matching il_fault (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
enable  in  1  scan enable; frame_start is ignored while low
frame_start  in  1  single-cycle frame tick
pos_rd_en  out  1  position/mask RAM read strobe
pos_raddr  out  ADDR_W  RAM read address
pos_x_rdata  in  32  signed X, valid 1 cycle after pos_rd_en
pos_y_rdata  in  32  signed Y, valid 1 cycle after pos_rd_en
mask_rdata  in  1  1 = BPM in interlock, valid 1 cycle after pos_rd_en
il_valid  out  1  datapath clock enable / sample strobe
il_addr  out  ADDR_W  posAddress to datapath
il_x  out  32  X to datapath
il_y  out  32  Y to datapath
il_fault  in  1  datapath fault flag, PIPE_LAT cycles after il_valid
scan_busy  out  1  high from READ through DRAIN
scan_done  out  1  1-cycle pulse at end of frame
frame_overrun  out  1  1-cycle pulse: frame_start arrived while not IDLE
fault_count_frame  out  16  faults in last completed frame
trip_latched  out  1  sticky interlock trip
first_fault_addr  out  ADDR_W  address of first fault since last clear
clear_req  in  1  level request to clear the trip
clear_ack  out  1  4-phase acknowledge

Behaviour:
- Reset (synchronous): state IDLE; all outputs 0; tag pipeline and counters cleared; trip cleared.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - enable=1 and frame_start=1 -> READ; addr=0, running count=0.
  - enable=0 ignores frame_start; no overrun is reported.
- READ:
  - pos_rd_en=1 and pos_raddr=addr; addr increments each cycle.
  - After issuing NUM_BPM-1 -> DRAIN.
- DRAIN: lasts exactly PIPE_LAT+2 cycles, then -> DONE.
- DONE: one cycle. scan_done=1. fault_count_frame takes the final running count (includes a fault returned in the last DRAIN cycle). Next state IDLE.
- Data path timing:
  - Stage 1 registers rd_en and raddr.
  - Stage 2 registers rdata into il_x/il_y and raddr into il_addr; il_valid = rd_en_d1 & mask_rdata.
  - Masked BPMs: il_valid=0; il_x/il_y/il_addr still update.
- Total timing: frame_start at cycle 0 gives rd_en on cycles 1..NUM_BPM, il_valid on 3..NUM_BPM+2, and scan_done at NUM_BPM+PIPE_LAT+3.
- Tag pipeline:
  - A PIPE_LAT-deep shift register carries {il_valid, il_addr}.
  - A fault counts only when tag valid=1 and il_fault=1. il_fault with a zero tag is ignored.
- Running count: 16 bits, increments by 1 per counted fault.
- Trip: a counted fault while trip_latched=0 sets trip_latched=1 and first_fault_addr=tag addr on the next edge. Later faults do not change either output.
- enable dropping mid-scan does not abort the frame; it only blocks the next start.
- frame_start while state!=IDLE: frame_overrun pulses for 1 cycle and the scan continues unaffected.
- Clear handshake:
  - clear_req=1 sampled in IDLE with clear_ack=0 -> trip_latched=0, first_fault_addr=0, clear_ack=1.
  - clear_ack stays high until clear_req=0, then drops the next cycle.
  - clear_req high outside IDLE is deferred until IDLE. No fault can coincide, because DRAIN empties the pipeline first.
- frame_start and a pending clear in the same IDLE cycle: the clear wins. The frame starts on a later tick; no overrun is reported.
- Reset mid-scan: immediate return to IDLE; no scan_done is produced.

Test Plan:
- Use NUM_BPM=8, PIPE_LAT=2 for all scenarios.
1. Reset asserted with random inputs -> all outputs 0; state IDLE.
2. All masks=1, no faults, frame_start at cycle 0 -> pos_rd_en on cycles 1-8; il_valid on 3-10 with il_addr 0..7; scan_done at cycle 13; fault_count_frame=0; trip_latched=0.
3. il_fault at addresses 3 and 5 (datapath model) -> trip_latched=1 from cycle 9; first_fault_addr=3; fault_count_frame=2 at scan_done.
4. Repeat 3 after clear with mask[3]=0 -> no il_valid for address 3; count=1; first_fault_addr=5; il_fault forced on a zero-tag cycle is ignored.
5. frame_start at cycle 5 mid-scan -> frame_overrun pulse at cycle 5; scan_done still at cycle 13; no second scan.
6. clear_req raised at cycle 4 of a tripped scan -> clear_ack rises only after scan_done (IDLE); trip_latched=0; drop clear_req and clear_ack falls a cycle later. Next frame with a fault at 6 -> first_fault_addr=6.

Source files
------------

// File: rtl/bm_interlock_scan_ctrl.sv
// Beam-monitor interlock frame sequencer: walks the position RAM on each frame tick,
// feeds X/Y to the comparator, counts returned faults and holds the trip until cleared.
module bm_interlock_scan_ctrl #(
  parameter int NUM_BPM  = 180,
  parameter int ADDR_W   = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              frame_start,
  output logic              pos_rd_en,
  output logic [ADDR_W-1:0] pos_raddr,
  input  logic [31:0]       pos_x_rdata,
  input  logic [31:0]       pos_y_rdata,
  input  logic              mask_rdata,
  output logic              il_valid,
  output logic [ADDR_W-1:0] il_addr,
  output logic [31:0]       il_x,
  output logic [31:0]       il_y,
  input  logic              il_fault,
  output logic              scan_busy,
  output logic              scan_done,
  output logic              frame_overrun,
  output logic [15:0]       fault_count_frame,
  output logic              trip_latched,
  output logic [ADDR_W-1:0] first_fault_addr,
  input  logic              clear_req,
  output logic              clear_ack
);

  localparam int CNT_W = $clog2(PIPE_LAT + 3);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(PIPE_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_BPM - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  drain_cnt;
  logic [15:0]       run_cnt;
  logic              clear_pend;
  logic              start;
  logic              fault_hit;

  logic              rd_en_p1;
  logic [ADDR_W-1:0] raddr_p1;
  logic [PIPE_LAT-1:0] tag_vld;
  logic [ADDR_W-1:0]   tag_addr [PIPE_LAT];

  // A pending clear in IDLE takes priority over a frame tick in the same cycle.
  assign clear_pend = clear_req & ~clear_ack;
  assign start      = enable & frame_start & ~clear_pend;
  assign fault_hit  = tag_vld[PIPE_LAT-1] & il_fault;
  assign pos_raddr  = addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      addr      <= (state == S_READ && addr != LAST_ADDR) ? addr + 1'b1 : '0;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt     = state;
    pos_rd_en     = 1'b0;
    scan_busy     = 1'b0;
    scan_done     = 1'b0;
    frame_overrun = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_READ;
      end
      S_READ: begin
        pos_rd_en     = 1'b1;
        scan_busy     = 1'b1;
        frame_overrun = frame_start;
        if (addr == LAST_ADDR) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        scan_busy     = 1'b1;
        frame_overrun = frame_start;
        if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        scan_done     = 1'b1;
        frame_overrun = frame_start;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage 1: read strobe and address aligned with the RAM access
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_p1 <= 1'b0;
      raddr_p1 <= '0;
    end else begin
      rd_en_p1 <= pos_rd_en;
      raddr_p1 <= pos_raddr;
    end
  end

  // Stage 2: RAM data presented to the comparator, masked BPMs carry no strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      il_valid <= 1'b0;
      il_addr  <= '0;
      il_x     <= '0;
      il_y     <= '0;
    end else begin
      il_valid <= rd_en_p1 & mask_rdata;
      if (rd_en_p1) begin
        il_addr <= raddr_p1;
        il_x    <= pos_x_rdata;
        il_y    <= pos_y_rdata;
      end
    end
  end

  // Tag pipeline: matches each returning il_fault to the sample that caused it
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_vld[i]  <= 1'b0;
        tag_addr[i] <= '0;
      end
    end else begin
      tag_vld[0]  <= il_valid;
      tag_addr[0] <= il_addr;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_addr[i] <= tag_addr[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt           <= '0;
      fault_count_frame <= '0;
      trip_latched      <= 1'b0;
      first_fault_addr  <= '0;
      clear_ack         <= 1'b0;
    end else begin
      if (state == S_IDLE && start)
        run_cnt <= '0;
      else if (fault_hit)
        run_cnt <= run_cnt + 16'd1;

      // Publish on entry to DONE so a fault in the last DRAIN cycle is included.
      if (state == S_DRAIN && state_nxt == S_DONE)
        fault_count_frame <= run_cnt + 16'(fault_hit);

      if (state == S_IDLE && clear_pend) begin
        trip_latched     <= 1'b0;
        first_fault_addr <= '0;
      end else if (fault_hit && !trip_latched) begin
        trip_latched     <= 1'b1;
        first_fault_addr <= tag_addr[PIPE_LAT-1];
      end

      if (state == S_IDLE && clear_pend)
        clear_ack <= 1'b1;
      else if (clear_ack && !clear_req)
        clear_ack <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bm_interlock_scan_ctrl.sv
// Bench for bm_interlock_scan_ctrl: RAM and comparator models around the DUT,
// frame expectations computed from per-address mask/fault sets.
module tb_bm_interlock_scan_ctrl;
  localparam int N   = 8;
  localparam int PL  = 2;
  localparam int AW  = 10;
  localparam int LEN = N + PL + 6;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, frame_start = 1'b0, clear_req = 1'b0, force_fault = 1'b0;
  logic pos_rd_en;
  logic [AW-1:0] pos_raddr;
  logic [31:0] pos_x_rdata = '0, pos_y_rdata = '0;
  logic mask_rdata = 1'b0;
  logic il_valid;
  logic [AW-1:0] il_addr;
  logic [31:0] il_x, il_y;
  logic il_fault;
  logic scan_busy, scan_done, frame_overrun;
  logic [15:0] fault_count_frame;
  logic trip_latched;
  logic [AW-1:0] first_fault_addr;
  logic clear_ack;

  logic [31:0] xmem [N];
  logic [31:0] ymem [N];
  logic mask_mem [N];
  logic flt_mem [N];
  logic dp0 = 1'b0, dp1 = 1'b0;

  int checks = 0;
  int errors = 0;
  bit m_trip = 1'b0;
  int m_ffa = 0;
  int m_cnt = 0;
  bit m_ack = 1'b0;

  typedef struct {
    logic en, fs, cr;
    logic busy, ack, trip, ovr;
    logic [AW-1:0] ffa;
  } vec_t;
  vec_t vtab [5];

  always #5 clk = ~clk;

  bm_interlock_scan_ctrl #(.NUM_BPM(N), .ADDR_W(AW), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .pos_rd_en(pos_rd_en), .pos_raddr(pos_raddr),
    .pos_x_rdata(pos_x_rdata), .pos_y_rdata(pos_y_rdata), .mask_rdata(mask_rdata),
    .il_valid(il_valid), .il_addr(il_addr), .il_x(il_x), .il_y(il_y), .il_fault(il_fault),
    .scan_busy(scan_busy), .scan_done(scan_done), .frame_overrun(frame_overrun),
    .fault_count_frame(fault_count_frame), .trip_latched(trip_latched),
    .first_fault_addr(first_fault_addr), .clear_req(clear_req), .clear_ack(clear_ack)
  );

  // Position/mask RAM with one cycle read latency, and a comparator that
  // flags configured addresses PL cycles after their strobe.
  always @(posedge clk) begin
    if (pos_rd_en) begin
      pos_x_rdata <= xmem[pos_raddr[2:0]];
      pos_y_rdata <= ymem[pos_raddr[2:0]];
      mask_rdata  <= mask_mem[pos_raddr[2:0]];
    end
    dp0 <= il_valid && flt_mem[il_addr[2:0]];
    dp1 <= dp0;
  end
  assign il_fault = dp1 | force_fault;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic bit mask_at(int a);
    return (a >= 0 && a < N) ? mask_mem[a] : 1'b0;
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int cyc, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [N-1:0] mk, input logic [N-1:0] fl);
    for (int a = 0; a < N; a++) begin
      mask_mem[a] = mk[a];
      flt_mem[a]  = fl[a];
      xmem[a]     = $urandom;
      ymem[a]     = $urandom;
    end
  endtask

  // One frame with frame_start at cycle 0; expectations from the scan timeline.
  task automatic run_frame(input int ovr_at, input int clr_at, input int force_at,
                           input bit rand_en, input bit rand_force);
    int fa, cnt, trip_c;
    bit tv;
    fa = -1;
    cnt = 0;
    for (int a = 0; a < N; a++)
      if (mask_mem[a] && flt_mem[a]) begin
        cnt++;
        if (fa < 0) fa = a;
      end
    trip_c = (!m_trip && fa >= 0) ? fa + PL + 4 : -1;
    for (int c = 0; c < LEN; c++) begin
      enable      = (c == 0 || !rand_en) ? 1'b1 : 1'($urandom_range(0, 1));
      frame_start = (c == 0) || (c == ovr_at);
      clear_req   = (clr_at >= 0 && c >= clr_at);
      tv          = (c >= PL + 3 && c < PL + 3 + N) && mask_at(c - PL - 3);
      force_fault = !tv && ((c == force_at) || (rand_force && $urandom_range(0, 2) == 0));
      @(negedge clk);
      if (c == trip_c) begin m_trip = 1'b1; m_ffa = fa; end
      if (c == N + PL + 3) m_cnt = cnt;
      if (clr_at >= 0 && c == N + PL + 5) begin m_trip = 1'b0; m_ffa = 0; m_ack = 1'b1; end
      chk(c, "pos_rd_en", 32'(pos_rd_en), 32'(c >= 1 && c <= N));
      chk(c, "pos_raddr", 32'(pos_raddr), (c >= 1 && c <= N) ? 32'(c - 1) : 32'd0);
      chk(c, "il_valid", 32'(il_valid), 32'(c >= 3 && c <= N + 2 && mask_at(c - 3)));
      if (c >= 3 && c <= N + 2) begin
        chk(c, "il_addr", 32'(il_addr), 32'(c - 3));
        chk(c, "il_x", il_x, xmem[c - 3]);
        chk(c, "il_y", il_y, ymem[c - 3]);
      end
      chk(c, "scan_busy", 32'(scan_busy), 32'(c >= 1 && c <= N + PL + 2));
      chk(c, "scan_done", 32'(scan_done), 32'(c == N + PL + 3));
      chk(c, "frame_overrun", 32'(frame_overrun), 32'(c == ovr_at));
      chk(c, "trip_latched", 32'(trip_latched), 32'(m_trip));
      chk(c, "first_fault_addr", 32'(first_fault_addr), 32'(m_ffa));
      chk(c, "fault_count_frame", 32'(fault_count_frame), 32'(m_cnt));
      chk(c, "clear_ack", 32'(clear_ack), 32'(m_ack));
      next_cyc();
    end
    enable = 1'b1;
    frame_start = 1'b0;
    force_fault = 1'b0;
  endtask

  task automatic do_clear();
    bit got;
    got = 1'b0;
    clear_req = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (clear_ack) got = 1'b1;
      next_cyc();
    end
    chk(0, "clear_ack_rise", 32'(got), 32'd1);
    clear_req = 1'b0;
    @(negedge clk);
    chk(0, "clear_trip", 32'(trip_latched), 32'd0);
    chk(0, "clear_ffa", 32'(first_fault_addr), 32'd0);
    chk(0, "clear_ack_hold", 32'(clear_ack), 32'd1);
    next_cyc();
    @(negedge clk);
    chk(1, "clear_ack_fall", 32'(clear_ack), 32'd0);
    next_cyc();
    m_trip = 1'b0;
    m_ffa = 0;
    m_ack = 1'b0;
  endtask

  initial begin
    logic [N-1:0] mk, fl;
    int ovr;
    set_cfg('1, '0);

    // Reset held with random control inputs
    for (int c = 0; c < 4; c++) begin
      enable      = 1'($urandom);
      frame_start = 1'($urandom);
      clear_req   = 1'($urandom);
      force_fault = 1'($urandom);
      @(negedge clk);
      if (c > 0) begin
        chk(c, "rst_ctrl", 32'({pos_rd_en, il_valid, scan_busy, scan_done, frame_overrun,
                                trip_latched, clear_ack}), 32'd0);
        chk(c, "rst_addr", 32'({pos_raddr, il_addr, first_fault_addr}), 32'd0);
        chk(c, "rst_il_x", il_x, 32'd0);
        chk(c, "rst_il_y", il_y, 32'd0);
        chk(c, "rst_count", 32'(fault_count_frame), 32'd0);
      end
      next_cyc();
    end
    reset = 1'b0; enable = 1'b0; frame_start = 1'b0; clear_req = 1'b0; force_fault = 1'b0;
    next_cyc();

    set_cfg(8'hFF, 8'h00);
    run_frame(-1, -1, -1, 1'b0, 1'b0);
    set_cfg(8'hFF, 8'b0010_1000);
    run_frame(-1, -1, -1, 1'b0, 1'b0);

    // Clear beats a same-cycle tick; enable low ignores the tick
    vtab[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd3};
    vtab[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0};
    vtab[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0};
    vtab[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    vtab[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    for (int i = 0; i < 5; i++) begin
      enable = vtab[i].en; frame_start = vtab[i].fs; clear_req = vtab[i].cr;
      @(negedge clk);
      chk(i, "tab_busy", 32'(scan_busy), 32'(vtab[i].busy));
      chk(i, "tab_ack", 32'(clear_ack), 32'(vtab[i].ack));
      chk(i, "tab_trip", 32'(trip_latched), 32'(vtab[i].trip));
      chk(i, "tab_ovr", 32'(frame_overrun), 32'(vtab[i].ovr));
      chk(i, "tab_ffa", 32'(first_fault_addr), 32'(vtab[i].ffa));
      next_cyc();
    end
    frame_start = 1'b0;
    m_trip = 1'b0; m_ffa = 0; m_ack = 1'b0;

    set_cfg(8'b1111_0111, 8'b0010_1000);
    run_frame(-1, -1, 8, 1'b0, 1'b0);
    run_frame(5, -1, -1, 1'b0, 1'b0);

    set_cfg(8'hFF, 8'b0000_1000);
    run_frame(-1, 4, -1, 1'b0, 1'b0);
    clear_req = 1'b0;
    @(negedge clk);
    chk(0, "ack_after_drop", 32'(clear_ack), 32'd1);
    next_cyc();
    @(negedge clk);
    chk(1, "ack_fall", 32'(clear_ack), 32'd0);
    chk(1, "trip_after_clear", 32'(trip_latched), 32'd0);
    next_cyc();
    m_ack = 1'b0;
    set_cfg(8'hFF, 8'b1100_0000);
    run_frame(-1, -1, -1, 1'b0, 1'b0);

    // Reset in the middle of a scan
    set_cfg(8'hFF, 8'h01);
    enable = 1'b1; frame_start = 1'b1;
    next_cyc();
    frame_start = 1'b0;
    for (int c = 1; c < 5; c++) next_cyc();
    @(negedge clk);
    chk(5, "mid_busy", 32'(scan_busy), 32'd1);
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
    m_trip = 1'b0; m_ffa = 0; m_cnt = 0; m_ack = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk(c, "rst_mid_busy", 32'(scan_busy), 32'd0);
      chk(c, "rst_mid_done", 32'(scan_done), 32'd0);
      chk(c, "rst_mid_rd", 32'(pos_rd_en), 32'd0);
      chk(c, "rst_mid_valid", 32'(il_valid), 32'd0);
      chk(c, "rst_mid_trip", 32'(trip_latched), 32'd0);
      chk(c, "rst_mid_count", 32'(fault_count_frame), 32'd0);
      next_cyc();
    end

    for (int f = 0; f < 24; f++) begin
      mk = N'($urandom);
      fl = N'($urandom) & N'($urandom);
      set_cfg(mk, fl);
      if ($urandom_range(0, 2) == 0) do_clear();
      ovr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, N + PL + 3)) : -1;
      run_frame(ovr, -1, -1, 1'b1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
